// File: rtl/normalization_ctrl.sv
// ---------------------------------------------------------------------------
// normalization_ctrl
//
// Iterative floating-point fraction normalizer. An operand (27-bit fraction
// with overflow and hidden bits, plus an 8-bit biased exponent) is loaded on
// start. The block then moves the fraction one bit per cycle until the hidden
// bit (bit25) is the leading one. It stops early on zero, exponent overflow or
// exponent underflow and reports the condition through a result flag.
//
// Ports
//   clk           in   1   sole clock, rising edge
//   rst_n         in   1   synchronous active-low reset
//   start         in   1   normalize request, sampled only in IDLE
//   fraction_in   in  27   bit26 overflow, bit25 hidden, 24:0 mantissa+guard
//   exp_in        in   8   biased exponent
//   busy          out  1   high while shifting
//   done          out  1   one-cycle completion pulse
//   fraction_out  out 27   registered fraction result
//   exp_out       out  8   registered exponent result
//   zero          out  1   result fraction was zero
//   overflow      out  1   exponent saturated high, fraction forced to 0
//   underflow     out  1   exponent hit the floor before normalization
//
// Configuration
//   NORM_STICKY_EN  when defined, a right shift ORs the bit shifted out of
//                   bit0 into the new bit0 so no set bit is lost.
// ---------------------------------------------------------------------------
module normalization_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [26:0] fraction_in,
  input  logic [7:0]  exp_in,
  output logic        busy,
  output logic        done,
  output logic [26:0] fraction_out,
  output logic [7:0]  exp_out,
  output logic        zero,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Exponent limits: a right shift is only legal while exp+1 stays below the
  // reserved all-ones code, and a left shift only while exp-1 stays above 0.
  localparam logic [7:0] EXP_RSHIFT_MAX = 8'hFD;
  localparam logic [7:0] EXP_LSHIFT_MIN = 8'h02;
  localparam logic [7:0] EXP_SATURATE   = 8'hFF;

  state_t      state, state_nxt;
  logic [26:0] frac_r, frac_nxt;
  logic [7:0]  exp_r, exp_nxt;
  logic        zero_r, zero_nxt;
  logic        ovf_r, ovf_nxt;
  logic        unf_r, unf_nxt;

  logic [26:0] frac_rsh;
  logic [26:0] frac_lsh;
  logic        frac_is_zero;
  logic        top_bit;
  logic        hidden_bit;

  // Candidate shift results. A 0 always enters at the vacated end; with the
  // sticky option the right shift folds the lost bit0 into the new bit0.
`ifdef NORM_STICKY_EN
  assign frac_rsh = {1'b0, frac_r[26:2], frac_r[1] | frac_r[0]};
`else
  assign frac_rsh = {1'b0, frac_r[26:1]};
`endif
  assign frac_lsh = {frac_r[25:0], 1'b0};

  assign frac_is_zero = (frac_r == 27'd0);
  assign top_bit      = frac_r[26];
  assign hidden_bit   = frac_r[25];

  // Next-state and datapath decode. In SHIFT the tests form a strict
  // priority chain: zero first, then the overflow bit, then the hidden bit,
  // and only a fraction with both top bits clear is shifted left.
  always_comb begin
    state_nxt = state;
    frac_nxt  = frac_r;
    exp_nxt   = exp_r;
    zero_nxt  = zero_r;
    ovf_nxt   = ovf_r;
    unf_nxt   = unf_r;

    case (state)
      IDLE: begin
        if (start) begin
          frac_nxt  = fraction_in;
          exp_nxt   = exp_in;
          zero_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (frac_is_zero) begin
          zero_nxt  = 1'b1;
          exp_nxt   = 8'd0;
          state_nxt = DONE;
        end else if (top_bit) begin
          if (exp_r <= EXP_RSHIFT_MAX) begin
            frac_nxt = frac_rsh;
            exp_nxt  = exp_r + 8'd1;
          end else begin
            frac_nxt  = 27'd0;
            exp_nxt   = EXP_SATURATE;
            ovf_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end else if (hidden_bit) begin
          state_nxt = DONE;
        end else if (exp_r >= EXP_LSHIFT_MIN) begin
          frac_nxt = frac_lsh;
          exp_nxt  = exp_r - 8'd1;
        end else begin
          exp_nxt   = 8'd0;
          unf_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and result registers. Reset is synchronous and wins over start,
  // so an operation in flight is dropped without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      frac_r <= 27'd0;
      exp_r  <= 8'd0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      frac_r <= frac_nxt;
      exp_r  <= exp_nxt;
      zero_r <= zero_nxt;
      ovf_r  <= ovf_nxt;
      unf_r  <= unf_nxt;
    end
  end

  assign busy         = (state == SHIFT);
  assign done         = (state == DONE);
  assign fraction_out = frac_r;
  assign exp_out      = exp_r;
  assign zero         = zero_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_normalization_ctrl.sv
// ---------------------------------------------------------------------------
// tb_normalization_ctrl
//
// Self-checking bench for normalization_ctrl. Each scenario task pushes the
// expected result and shift count of every operation into a scoreboard,
// launches the operation, and pops/compares when done is seen.
// ---------------------------------------------------------------------------
module tb_normalization_ctrl;

  typedef struct packed {
    logic [26:0] frac;
    logic [7:0]  expo;
    logic        z;
    logic        o;
    logic        u;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [26:0] fraction_in;
  logic [7:0]  exp_in;
  logic        busy;
  logic        done;
  logic [26:0] fraction_out;
  logic [7:0]  exp_out;
  logic        zero;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  res_t sb_res[$];
  int   sb_lat[$];

  normalization_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .fraction_in  (fraction_in),
    .exp_in       (exp_in),
    .busy         (busy),
    .done         (done),
    .fraction_out (fraction_out),
    .exp_out      (exp_out),
    .zero         (zero),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done. Inputs are scrambled
  // after the accepting edge; with poke, start is re-asserted while busy.
  task automatic run_op(input logic [26:0] fin, input logic [7:0] ein,
                        input bit poke, output res_t got, output int lat,
                        output int busy_cycles, output bit timed_out);
    got         = '0;
    lat         = -1;
    busy_cycles = 0;
    timed_out   = 1'b1;
    @(posedge clk); #1;
    start       = 1'b1;
    fraction_in = fin;
    exp_in      = ein;
    @(posedge clk); #1;
    start       = 1'b0;
    fraction_in = 27'($urandom);
    exp_in      = 8'($urandom);
    if (busy) busy_cycles++;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k <= 2) begin
        start       = 1'b1;
        fraction_in = 27'h0;
        exp_in      = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        got       = {fraction_out, exp_out, zero, overflow, underflow};
        lat       = k - 1;
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset(input string tag);
    logic [39:0] obs;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {busy, done, fraction_out, exp_out, zero, overflow, underflow};
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("[TB] FAIL %s outputs in reset got %h required 0", tag, obs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_normalized();
    logic [26:0] fin [3] = '{27'h2000000, 27'h2000000, 27'h3FFFFFF};
    logic [7:0]  ein [3] = '{8'h80, 8'h00, 8'hFF};
    res_t        er  [3] = '{{27'h2000000, 8'h80, 3'b000},
                             {27'h2000000, 8'h00, 3'b000},
                             {27'h3FFFFFF, 8'hFF, 3'b000}};
    res_t got, want;
    int lat, bc, want_n;
    bit to;
    for (int i = 0; i < 3; i++) begin
      sb_res.push_back(er[i]);
      sb_lat.push_back(0);
      run_op(fin[i], ein[i], 1'b0, got, lat, bc, to);
      want = sb_res.pop_front();
      want_n = sb_lat.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL normalized[%0d] timeout got no done required done", i);
      end else begin
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL normalized[%0d] result got %h required %h", i, got, want);
        end
        checks++;
        if (lat !== want_n) begin
          errors++;
          $display("[TB] FAIL normalized[%0d] shifts got %0d required %0d", i, lat, want_n);
        end
      end
    end
  endtask

  task automatic test_right_shift();
    logic [26:0] fin [3] = '{27'h4000000, 27'h4000000, 27'h6000000};
    logic [7:0]  ein [3] = '{8'hC0, 8'hFD, 8'h10};
    res_t        er  [3] = '{{27'h2000000, 8'hC1, 3'b000},
                             {27'h2000000, 8'hFE, 3'b000},
                             {27'h3000000, 8'h11, 3'b000}};
    res_t got, want;
    int lat, bc, want_n;
    bit to;
    for (int i = 0; i < 3; i++) begin
      sb_res.push_back(er[i]);
      sb_lat.push_back(1);
      run_op(fin[i], ein[i], 1'b0, got, lat, bc, to);
      want = sb_res.pop_front();
      want_n = sb_lat.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL right_shift[%0d] timeout got no done required done", i);
      end else begin
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL right_shift[%0d] result got %h required %h", i, got, want);
        end
        checks++;
        if (lat !== want_n) begin
          errors++;
          $display("[TB] FAIL right_shift[%0d] shifts got %0d required %0d", i, lat, want_n);
        end
      end
    end
  endtask

  task automatic test_left_shift();
    logic [26:0] fin  [3] = '{27'h0800000, 27'h1000000, 27'h0000001};
    logic [7:0]  ein  [3] = '{8'hC0, 8'h80, 8'h80};
    res_t        er   [3] = '{{27'h2000000, 8'hBE, 3'b000},
                              {27'h2000000, 8'h7F, 3'b000},
                              {27'h2000000, 8'h67, 3'b000}};
    int          en   [3] = '{2, 1, 25};
    bit          pk   [3] = '{1'b1, 1'b0, 1'b0};
    res_t got, want;
    int lat, bc, want_n;
    bit to;
    for (int i = 0; i < 3; i++) begin
      sb_res.push_back(er[i]);
      sb_lat.push_back(en[i]);
      run_op(fin[i], ein[i], pk[i], got, lat, bc, to);
      want = sb_res.pop_front();
      want_n = sb_lat.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL left_shift[%0d] timeout got no done required done", i);
      end else begin
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL left_shift[%0d] result got %h required %h", i, got, want);
        end
        checks++;
        if (lat !== want_n) begin
          errors++;
          $display("[TB] FAIL left_shift[%0d] shifts got %0d required %0d", i, lat, want_n);
        end
        checks++;
        if (bc !== want_n + 1) begin
          errors++;
          $display("[TB] FAIL left_shift[%0d] busy cycles got %0d required %0d", i, bc, want_n + 1);
        end
      end
    end
  endtask

  task automatic test_zero_overflow();
    logic [26:0] fin [3] = '{27'h0000000, 27'h4000000, 27'h4000000};
    logic [7:0]  ein [3] = '{8'h55, 8'hFE, 8'hFF};
    res_t        er  [3] = '{{27'h0000000, 8'h00, 3'b100},
                             {27'h0000000, 8'hFF, 3'b010},
                             {27'h0000000, 8'hFF, 3'b010}};
    res_t got, want;
    int lat, bc, want_n;
    bit to;
    for (int i = 0; i < 3; i++) begin
      sb_res.push_back(er[i]);
      sb_lat.push_back(0);
      run_op(fin[i], ein[i], 1'b0, got, lat, bc, to);
      want = sb_res.pop_front();
      want_n = sb_lat.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL zero_ovf[%0d] timeout got no done required done", i);
      end else begin
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL zero_ovf[%0d] result got %h required %h", i, got, want);
        end
        checks++;
        if (lat !== want_n) begin
          errors++;
          $display("[TB] FAIL zero_ovf[%0d] shifts got %0d required %0d", i, lat, want_n);
        end
      end
    end
  endtask

  task automatic test_underflow();
    logic [26:0] fin [3] = '{27'h0200000, 27'h1000000, 27'h0000001};
    logic [7:0]  ein [3] = '{8'h02, 8'h01, 8'h00};
    res_t        er  [3] = '{{27'h0400000, 8'h00, 3'b001},
                             {27'h1000000, 8'h00, 3'b001},
                             {27'h0000001, 8'h00, 3'b001}};
    int          en  [3] = '{1, 0, 0};
    res_t got, want;
    int lat, bc, want_n;
    bit to;
    for (int i = 0; i < 3; i++) begin
      sb_res.push_back(er[i]);
      sb_lat.push_back(en[i]);
      run_op(fin[i], ein[i], 1'b0, got, lat, bc, to);
      want = sb_res.pop_front();
      want_n = sb_lat.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL underflow[%0d] timeout got no done required done", i);
      end else begin
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL underflow[%0d] result got %h required %h", i, got, want);
        end
        checks++;
        if (lat !== want_n) begin
          errors++;
          $display("[TB] FAIL underflow[%0d] shifts got %0d required %0d", i, lat, want_n);
        end
      end
    end
  endtask

  task automatic test_sticky();
    res_t got, want;
    int lat, bc, want_n;
    bit to;
`ifdef NORM_STICKY_EN
    sb_res.push_back({27'h2000001, 8'h11, 3'b000});
`else
    sb_res.push_back({27'h2000000, 8'h11, 3'b000});
`endif
    sb_lat.push_back(1);
    run_op(27'h4000001, 8'h10, 1'b0, got, lat, bc, to);
    want = sb_res.pop_front();
    want_n = sb_lat.pop_front();
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL sticky timeout got no done required done");
    end else begin
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL sticky result got %h required %h", got, want);
      end
      checks++;
      if (lat !== want_n) begin
        errors++;
        $display("[TB] FAIL sticky shifts got %0d required %0d", lat, want_n);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [39:0] obs;
    int done_seen;
    @(posedge clk); #1;
    start       = 1'b1;
    fraction_in = 27'h0000001;
    exp_in      = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    obs = {busy, done, fraction_out, exp_out, zero, overflow, underflow};
    checks++;
    if (obs !== 40'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_shift outputs got %h required 0", obs);
    end
    start = 1'b0;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_shift done/busy cycles after abort got %0d required 0", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    res_t got, want, held;
    int lat, bc, want_n, stray;
    bit to;
    sb_res.push_back({27'h0000000, 8'hFF, 3'b010});
    sb_lat.push_back(0);
    sb_res.push_back({27'h2000000, 8'hC1, 3'b000});
    sb_lat.push_back(1);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) run_op(27'h4000000, 8'hFE, 1'b0, got, lat, bc, to);
      else        run_op(27'h4000000, 8'hC0, 1'b0, got, lat, bc, to);
      want = sb_res.pop_front();
      want_n = sb_lat.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d] timeout got no done required done", i);
      end else begin
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL back_to_back[%0d] result got %h required %h", i, got, want);
        end
        checks++;
        if (lat !== want_n) begin
          errors++;
          $display("[TB] FAIL back_to_back[%0d] shifts got %0d required %0d", i, lat, want_n);
        end
      end
      held = want;
    end
    stray = 0;
    fraction_in = 27'h1234567;
    exp_in      = 8'h33;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("[TB] FAIL hold done/busy cycles in idle got %0d required 0", stray);
    end
    checks++;
    if ({fraction_out, exp_out, zero, overflow, underflow} !== held) begin
      errors++;
      $display("[TB] FAIL hold idle result got %h required %h",
               {fraction_out, exp_out, zero, overflow, underflow}, held);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    fraction_in = 27'd0;
    exp_in      = 8'd0;
    test_reset("reset_initial");
    test_normalized();
    test_right_shift();
    test_left_shift();
    test_zero_overflow();
    test_reset("reset_after_overflow");
    test_underflow();
    test_sticky();
    test_reset_mid_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/normalization_ctrl.md
NORMALIZATION_CTRL -- requirements
Module: normalization_ctrl

Interface
REQ-001 The block SHALL have these ports: clk, input, 1 bit, sole clock; all state changes on the rising edge.
REQ-002 The block SHALL have these ports: rst_n, input, 1 bit, synchronous active-low reset.
REQ-003 The block SHALL have these ports: start, input, 1 bit, request to normalize; sampled only in IDLE.
REQ-004 The block SHALL have these ports: fraction_in, input, 27 bits; bit26 = overflow, bit25 = hidden, bits 24:0 = mantissa plus guard.
REQ-005 The block SHALL have these ports: exp_in, input, 8 bits, biased exponent.
REQ-006 The block SHALL have these ports: busy, output, 1 bit, high while in SHIFT.
REQ-007 The block SHALL have these ports: done, output, 1 bit, one-cycle pulse, high exactly while in DONE.
REQ-008 The block SHALL have these ports: fraction_out, output, 27 bits, registered result.
REQ-009 The block SHALL have these ports: exp_out, output, 8 bits, registered result.
REQ-010 The block SHALL have these ports: zero, overflow and underflow, outputs, 1 bit each, result flags, valid with done and held until the next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 SHALL load fraction_in and exp_in into internal registers, clear all flags, and move to SHIFT.
REQ-013 In SHIFT, one step per cycle SHALL be performed, with priority as follows.
- a) fraction==0: zero=1, exp=0, go to DONE.
- b) bit26=1 and exp<=0xFD: shift right 1 bit, exp+1, stay in SHIFT.
- c) bit26=1 and exp>=0xFE: exp=0xFF, fraction=0, overflow=1, go to DONE.
- d) bit26=0 and bit25=1: go to DONE (normalized).
- e) bit25:26==0 and exp>=2: shift left 1 bit, exp-1, stay in SHIFT.
- f) bit25:26==0 and exp<=1: exp=0, fraction unchanged, underflow=1, go to DONE.
REQ-014 DONE SHALL last one cycle and then return to IDLE; start is ignored in SHIFT and DONE.
REQ-015 Latency: with start sampled at edge 0 and n shifts performed, done SHALL be high between edge n+1 and edge n+2; the maximum n is 25.
REQ-016 fraction_out and exp_out SHALL equal the internal registers and SHALL hold their values in IDLE until the next accepted start.
REQ-017 Left shifts SHALL insert 0 at bit0; right shifts SHALL insert 0 at bit26.
REQ-018 Exponent arithmetic SHALL be 8-bit unsigned and never wrap, per REQ-013 c/f.

Reset
REQ-019 With rst_n=0 at a clock edge, the block SHALL enter IDLE, and busy, done, zero, overflow, underflow, fraction_out and exp_out SHALL all be 0.
REQ-020 Reset during SHIFT SHALL abort the operation with no done pulse; rst_n SHALL have priority over start.

Configuration
REQ-021 When macro NORM_STICKY_EN is defined, a right shift SHALL OR the shifted-out bit0 into the new bit0 (sticky).
REQ-022 When NORM_STICKY_EN is undefined, the shifted-out bit SHALL be discarded.

Verification
REQ-023 Case: fraction_in=27'h2000000, exp_in=8'h80. Required: done at n=0, fraction_out=27'h2000000, exp_out=8'h80, all flags 0.
REQ-024 Case: fraction_in=27'h4000000, exp_in=8'hC0. Required: n=1, fraction_out=27'h2000000, exp_out=8'hC1.
REQ-025 Case: fraction_in=27'h0800000, exp_in=8'hC0. Required: n=2, fraction_out=27'h2000000, exp_out=8'hBE; a start pulsed while busy is ignored.
REQ-026 Case: fraction_in=0, exp_in=8'h55. Required: zero=1, exp_out=0. Case: fraction_in=27'h4000000, exp_in=8'hFE. Required: overflow=1, exp_out=8'hFF, fraction_out=0.
REQ-027 Case: fraction_in=27'h0200000, exp_in=8'h02. Required: one left shift, then underflow=1, exp_out=0, fraction_out=27'h0400000.
REQ-028 Case: fraction_in=27'h4000001, exp_in=8'h10. Required: fraction_out=27'h2000001 with NORM_STICKY_EN, 27'h2000000 without.
REQ-029 Case: rst_n=0 asserted mid-SHIFT. Required: next cycle is IDLE, all outputs 0, and no done pulse.
